// File: rtl/fwd_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : type_pkg
//  Description : Shared types and constants for the operand-forwarding
//                scoreboard: register bus types, the scoreboard entry
//                record and the architectural zero register.
//  Revision    : 1.0 - initial release
// ============================================================================
package type_pkg;

    // Existing datapath bus types.
    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;

    // x0 is hard-wired to zero and never produces a forwardable result.
    localparam RegAddrBus ZERO_REG  = 5'd0;

    // Deepest pipeline the scoreboard is intended to track.
    localparam int        DEPTH_MAX = 8;

    // One in-flight write: destination, producer kind and captured result.
    typedef struct packed {
        logic      valid;
        RegAddrBus rd;
        logic      is_load;
        RegBus     data;
    } sb_entry_t;

endpackage : type_pkg
`default_nettype wire

// File: rtl/fwd_scoreboard_port_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_port_sel
//  Description : Per-read-port forwarding selector. Finds the youngest
//                valid scoreboard entry whose destination matches the
//                source register, muxes its data over the register-file
//                value, and flags a load-use hazard when that entry is a
//                load still in EX.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_port_sel
    import type_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3
) (
    input  logic [DEPTH-1:0]      i_valid,
    input  logic [DEPTH*AW-1:0]   i_rd,
    input  logic [DEPTH*XLEN-1:0] i_data,
    input  logic                  i_ex_is_load,
    input  logic [AW-1:0]         i_rs,
    input  logic [XLEN-1:0]       i_rf_rdata,
    output logic [XLEN-1:0]       o_data,
    output logic                  o_hazard,
    output logic                  o_fwd
);

    // Oldest-to-youngest scan so the youngest match overrides older ones.
    always_comb begin
        o_data   = i_rf_rdata;
        o_hazard = 1'b0;
        o_fwd    = 1'b0;
        if (i_rs != AW'(ZERO_REG)) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (i_valid[k] && (i_rd[k*AW +: AW] == i_rs)) begin
                    if ((k == 0) && i_ex_is_load) begin
                        // Load data does not exist yet: fall back to the
                        // register file and let the stall hold ID.
                        o_data   = i_rf_rdata;
                        o_hazard = 1'b1;
                        o_fwd    = 1'b0;
                    end else begin
                        o_data   = i_data[k*XLEN +: XLEN];
                        o_hazard = 1'b0;
                        o_fwd    = 1'b1;
                    end
                end
            end
        end
    end

endmodule : fwd_port_sel
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_scoreboard
//  Description : Operand-forwarding unit with an in-flight write
//                scoreboard. Tracks destinations of instructions in EX..WB
//                in a DEPTH-entry shift register, captures their results as
//                they advance, forwards the youngest match to each ID read
//                port and raises a load-use stall.
//  Options     : FWD_PERF_EN - adds saturating stall/forward counters
//                (perf_stall_cnt_o, perf_fwd_cnt_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard
    import type_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int NUM_RPORTS = 2,
    parameter int DEPTH      = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       adv_i,
    input  logic                       flush_i,
    input  logic                       iss_valid_i,
    input  logic                       iss_we_i,
    input  logic                       iss_is_load_i,
    input  logic [AW-1:0]              iss_rd_i,
    input  logic [XLEN-1:0]            ex_data_i,
    input  logic [XLEN-1:0]            mem_data_i,
    input  logic [NUM_RPORTS*AW-1:0]   rs_i,
    input  logic [NUM_RPORTS*XLEN-1:0] rf_rdata_i,
    output logic [NUM_RPORTS*AW-1:0]   rf_raddr_o,
    output logic [NUM_RPORTS*XLEN-1:0] op_data_o,
    output logic                       stall_o
`ifdef FWD_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt_o,
    output logic [31:0]                perf_fwd_cnt_o
`endif
);

    // Entry 0 = EX, 1 = MEM, 2..DEPTH-1 = later stages. Only EX and MEM
    // need the producer kind; older entries always hold final data.
    logic [DEPTH-1:0]  r_valid;
    logic [1:0]        r_is_load;
    logic [AW-1:0]     r_rd   [DEPTH];
    logic [XLEN-1:0]   r_data [1:DEPTH-1];

    logic                  w_issue;
    logic [DEPTH*AW-1:0]   w_rd_flat;
    logic [DEPTH*XLEN-1:0] w_data_flat;
    logic [NUM_RPORTS-1:0] w_hazard;
    logic [NUM_RPORTS-1:0] w_fwd;

    // A write to x0 or a non-writing instruction occupies EX as a bubble.
    assign w_issue = iss_valid_i && iss_we_i && (iss_rd_i != AW'(ZERO_REG))
                     && !stall_o && !flush_i;

    // Effective forward value of each entry: live sources for EX and a
    // load in MEM, captured data everywhere else.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_ent
            assign w_rd_flat[k*AW +: AW] = r_rd[k];
            if (k == 0) begin : g_ex
                assign w_data_flat[k*XLEN +: XLEN] = ex_data_i;
            end else if (k == 1) begin : g_mem
                assign w_data_flat[k*XLEN +: XLEN] = r_is_load[1] ? mem_data_i : r_data[1];
            end else begin : g_late
                assign w_data_flat[k*XLEN +: XLEN] = r_data[k];
            end
        end
    endgenerate

    // Scoreboard shift register: advance, hold, or kill the EX entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_is_load <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else if (adv_i) begin
            r_valid[0]   <= w_issue;
            r_rd[0]      <= w_issue ? iss_rd_i : '0;
            r_is_load[0] <= w_issue && iss_is_load_i;
            r_is_load[1] <= r_valid[0] && r_is_load[0];
            // ALU result is captured on its way out of EX.
            r_data[1]    <= (r_valid[0] && !r_is_load[0]) ? ex_data_i : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            for (int k = 2; k < DEPTH; k++) begin
                if (k == 2) begin
                    // Load data is captured on its way out of MEM.
                    r_data[k] <= r_is_load[1] ? mem_data_i : r_data[k-1];
                end else begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end else if (flush_i) begin
            r_valid[0] <= 1'b0;
        end
    end

    assign rf_raddr_o = rs_i;

    // One priority selector per source-operand read port.
    generate
        for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
            fwd_port_sel #(
                .XLEN  (XLEN),
                .AW    (AW),
                .DEPTH (DEPTH)
            ) u_sel (
                .i_valid      (r_valid),
                .i_rd         (w_rd_flat),
                .i_data       (w_data_flat),
                .i_ex_is_load (r_is_load[0]),
                .i_rs         (rs_i[p*AW +: AW]),
                .i_rf_rdata   (rf_rdata_i[p*XLEN +: XLEN]),
                .o_data       (op_data_o[p*XLEN +: XLEN]),
                .o_hazard     (w_hazard[p]),
                .o_fwd        (w_fwd[p])
            );
        end
    endgenerate

    assign stall_o = |w_hazard;

`ifdef FWD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;
    logic [31:0] w_fwd_inc;
    logic [32:0] w_fwd_sum;

    // Number of ports served from a scoreboard entry this cycle.
    always_comb begin
        w_fwd_inc = '0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            w_fwd_inc = w_fwd_inc + {31'd0, w_fwd[p]};
        end
    end

    assign w_fwd_sum = {1'b0, r_fwd_cnt} + {1'b0, w_fwd_inc};

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stall_o && adv_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            r_fwd_cnt <= w_fwd_sum[32] ? '1 : w_fwd_sum[31:0];
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
    assign perf_fwd_cnt_o   = r_fwd_cnt;
`else
    // Forward-hit flags have no consumer without the counters.
    logic w_unused_fwd;
    assign w_unused_fwd = ^w_fwd;
`endif

endmodule : fwd_scoreboard
`default_nettype wire

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand-forwarding unit with an in-flight write scoreboard; successor to the 2-port EX/MEM bypass mux.
- Tracks the destinations of instructions in EX..WB in a DEPTH-entry shift register and captures their results as they advance.
- Forwards the youngest matching value to NUM_RPORTS ID read ports.
- Raises a load-use stall when the youngest match is a load still in EX.
- Sits between ID, the register file and EX/MEM.

Parameters:
- XLEN, 32, data width (matches RegBus).
- AW, 5, register address width (matches RegAddrBus).
- NUM_RPORTS, 2, number of source-operand read ports.
- DEPTH, 3, tracked stages: entry 0 = EX, 1 = MEM, 2..DEPTH-1 = later stages up to WB. Legal range 2..8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- adv_i  in  1  pipeline advances this cycle (no external hold)
- flush_i  in  1  kill instruction entering EX and entry 0
- iss_valid_i  in  1  ID presents an instruction
- iss_we_i  in  1  instruction writes rd
- iss_is_load_i  in  1  instruction is a load
- iss_rd_i  in  AW  destination register
- ex_data_i  in  XLEN  live ALU result of entry 0
- mem_data_i  in  XLEN  live load data of entry 1
- rs_i  in  NUM_RPORTS*AW  source addresses, port p at [p*AW +: AW]
- rf_rdata_i  in  NUM_RPORTS*XLEN  register-file read data
- rf_raddr_o  out  NUM_RPORTS*AW  register-file read addresses
- op_data_o  out  NUM_RPORTS*XLEN  resolved operands to EX
- stall_o  out  1  load-use hazard; ID must hold

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all entries invalid, addr 0, data 0. Outputs therefore read stall_o=0, op_data_o=rf_rdata_i, rf_raddr_o=rs_i.
- Entry fields: valid, rd, is_load, data. An entry is valid only if we=1 and rd!=0.
- rf_raddr_o: equals rs_i per port, always; it is combinational.
- Forward sources, per port and per valid entry k with rd==rs:
  - k=0, non-load: ex_data_i (live).
  - k=0, load: not available; this is a hazard.
  - k=1, load: mem_data_i (live).
  - k=1 non-load, or any k>=2: stored data.
- Forwarding priority: the lowest k wins (youngest instruction).
- x0 handling: rs==0 never matches; op_data_o = rf_rdata_i.
- No match: op_data_o = rf_rdata_i. The register file is write-first, so a retired value is visible on the next cycle.
- stall_o: combinational OR over ports of "the youngest match is entry 0 with is_load". An older match to the same register does not suppress the stall.
- Shift on adv_i=1:
  - entry0 <= issued instruction if iss_valid_i && !stall_o && !flush_i, otherwise a bubble (valid=0).
  - entry1.data <= ex_data_i when entry0 is a non-load.
  - entry2.data <= mem_data_i when entry1 is a load, otherwise entry1.data.
  - entries k>=3 copy entry k-1.
  - entry DEPTH-1 is discarded.
- adv_i=0: all entries hold. Live sources keep being used. flush_i still clears entry0.valid.
- flush_i with adv_i=1: entry0 becomes a bubble and older entries shift normally.
- Latency: forwarding is zero-cycle combinational. Capture is one clock per stage.
- Async reset mid-operation clears all entries immediately; stall_o drops in the same cycle.

Optional Feature:
- Macro: FWD_PERF_EN.
- When defined, add outputs perf_stall_cnt_o (32) and perf_fwd_cnt_o (32).
  - perf_stall_cnt_o increments each cycle stall_o=1 && adv_i=1.
  - perf_fwd_cnt_o increments by the number of ports forwarded from a scoreboard entry that cycle.
  - Both saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package type_pkg holds:
  - sb_entry_t (valid, rd, is_load, data).
  - constants ZERO_REG and DEPTH_MAX=8.
  - existing RegBus and RegAddrBus types.
- Sub-module fwd_port_sel, instantiated NUM_RPORTS times: per-port priority match, mux and hazard bit over the entry array.

Test Plan:
- ALU back-to-back: issue add x5 (ex_data_i=0x11), next cycle rs_i[0]=5 -> op_data_o[0]=0x11, stall_o=0.
- Load-use: issue lw x6, next ID rs_i[1]=6 -> stall_o=1 for one cycle. Following cycle mem_data_i=0xDEAD -> op_data_o[1]=0xDEAD, stall_o=0.
- Priority: x7 written by entries 2 (0xAA) and 1 (0xBB) -> op_data_o=0xBB. An x0 destination never forwards: rs=0 -> rf_rdata_i.
- Hold: adv_i=0 for 3 cycles with entry1 ALU data 0x55 -> op_data_o stays 0x55 and entries are unchanged.
- Flush: lw x8 entering EX with flush_i=1, then rs=8 -> stall_o=0, op_data_o=rf_rdata_i.
- Reset mid-stall: assert rst_n=0 while stall_o=1 -> stall_o=0 immediately. With FWD_PERF_EN defined, both counters read 0.
